seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed scanner for a 4-digit common-anode seven-segment display. Holds a 16-bit hex word and steps through its four nibbles, one per refresh slot. Each cycle it presents the active nibble to the downstream `seven_display` decoder, together with active-low anode enables and a decimal point. Between digits it inserts a dead time to suppress ghosting, and it can optionally blank leading zeros.

## Interface
Parameters:
- `DIV`, default 50000: clock cycles per digit slot; legal range is 2 or more.
- `DEAD`, default 2: cycles at the start of each slot with all anodes off; legal range is 0 to DIV-1.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `data` and `dp_in`.
- `data`  in  16  four hex digits; digit 0 is `data[3:0]`, digit 3 is `data[15:12]`.
- `dp_in`  in  4  per-digit decimal point request, active-high; bit i belongs to digit i.
- `blank_lz`  in  1  level input; when high, leading-zero blanking is enabled.
- `value`  out  4  nibble of the active digit; drives the decoder's `value` input.
- `an`  out  4  anode enables, active-low; bit i selects digit i.
- `dp`  out  1  decimal point segment, active-low.
- `frame`  out  1  one-cycle pulse on the first cycle of each digit-0 slot.

## Operation
- **Slot counter `cnt`.** Counts 0..DIV-1 and then wraps to 0. The cycle in which it returns to 0 is a slot boundary.
- **Digit index `idx`.** Advances at every slot boundary in the sequence 0→1→2→3→0.
- **Pending/shadow registers.**
  - `load` writes `data`/`dp_in` into a pending register and sets a pending flag.
  - A later `load` before the boundary overwrites the pending register; the last write wins.
  - At a slot boundary, if the pending flag is set, the pending register copies into the display shadow and the flag clears.
  - The display never changes content mid-slot.
- **Load coinciding with the boundary.** A `load` asserted in the cycle where `cnt`==DIV-1 is transferred at that same boundary. The new slot already shows it.
- **Outputs, as seen in the cycle where `cnt`=k.**
  - `value` = shadow nibble[`idx`], for every k.
  - `an`: 4'b1111 when k < DEAD. Otherwise bit `idx` is low and the others are high, unless the digit is blanked.
  - `dp`: the inverse of shadow `dp[idx]` when the digit is enabled; 1 otherwise.
- **Leading-zero blanking.** Applies only when `blank_lz` is high. Digit i (i = 3, 2 or 1) is blanked if shadow digits 3 down to i are all 4'h0. Digit 0 is never blanked.
  - A blanked digit keeps `an` = 4'b1111 and `dp` = 1 for its whole slot.
  - Its `value` is still driven.
  - A set dp bit does not override blanking.
- **Live control input.** `blank_lz` is sampled every cycle and is not shadowed.
- **`frame`.** High in exactly the cycle where `idx`==0 and `cnt`==0; low otherwise.
- **Reset.**
  - Asserting `rst` at any time, including mid-slot or with a load pending, forces the following immediately:
    - `cnt` = 0, `idx` = 0, shadow = 0, pending register = 0, pending flag = 0;
    - `an` = 4'b1111, `value` = 4'h0, `dp` = 1, `frame` = 0.
  - On the first clock after release, `cnt` becomes 1. The first slot therefore shows all anodes off for its remaining DEAD-1 cycles, if any, and then digit 0 with value 0.

## Timing
- All outputs are registered, or are decoded purely from registered state. There is no combinational path from inputs to outputs.
- **Period.**
  - Slot length is exactly DIV cycles.
  - Frame period is 4·DIV cycles.
  - Refresh rate is f_clk / (4·DIV).
- **Load latency.** From `load` to visible content is 1 to DIV cycles. It is 1 when `load` falls at `cnt`==DIV-1, and DIV when it falls at `cnt`==0.
- **Dead time.** Within each slot, anodes are enabled for exactly DIV-DEAD cycles. With DEAD=0 there is never an all-off cycle between digits.
- **Index and anodes change together.** `idx` and `value` change in the same cycle as the anode pattern. With DEAD ≥ 1, the anodes are already off at that point.

## Test plan
- **Reset and first frame.** DIV=8, DEAD=2; hold `rst` for 3 cycles, then release.
  - During reset, outputs must be `an`=1111, `value`=0, `dp`=1, `frame`=0.
  - After release: `an`=1110 during `cnt` 2..7.
  - `frame` pulses every 32 cycles, first at the slot starting 32 cycles after `cnt`=0.
- **Basic scan.** DIV=8, DEAD=2; `load` `data`=16'h1A2F, `dp_in`=4'b0100, `blank_lz`=0.
  - Successive slots show `value` F, 2, A, 1.
  - `an` steps through 1110, 1101, 1011, 0111, each for 6 cycles after 2 all-off cycles.
  - `dp`=0 only in the digit-2 slot.
- **Mid-slot load isolation.** Load 16'h1111 at `cnt`=3 of the digit-1 slot, after showing 16'h1A2F.
  - `value` must stay 2 until the boundary.
  - The digit-2 slot must then show 1.
  - Two loads within one slot: only the second appears.
- **Boundary load.** Assert `load` with 16'h00C0 exactly at `cnt`=7; the next slot must show the new nibble.
- **Leading-zero blanking.** `blank_lz`=1 with `data`=16'h0050:
  - digits 3 and 2 keep `an`=1111 for their whole slots;
  - digit 1 shows 5 and digit 0 shows 0.
  - With `data`=16'h0000, only digit 0 lights, showing 0.
  - With `data`=16'h0000 and `dp_in`=4'b1000, `dp` stays 1 throughout.
- **Reset mid-operation.** Assert `rst` in the digit-2 slot while a load is pending.
  - All outputs return to their reset values within the same cycle.
  - After release, the pending data must never appear; the display shows 0.

Source files
------------

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display.
// A 16-bit hex word is held in a display shadow register and its four nibbles
// are presented one per refresh slot to a downstream seven-segment decoder.
// Each slot starts with DEAD cycles of all-anodes-off to suppress ghosting.
// Leading zeros can optionally be blanked.
//
// New content arrives through a pending register and is only copied into the
// shadow at a slot boundary, so a digit never changes content mid-slot.
//
// Parameters:
//   DIV      clock cycles per digit slot (>= 2)
//   DEAD     all-off cycles at the start of each slot (0 .. DIV-1)
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   load      in   1   single-cycle strobe capturing data/dp_in
//   data      in  16   four hex digits, digit 0 = data[3:0]
//   dp_in     in   4   per-digit decimal point request, active-high
//   blank_lz  in   1   leading-zero blanking enable (live level)
//   value     out  4   nibble of the active digit (to the decoder)
//   an        out  4   anode enables, active-low, bit i = digit i
//   dp        out  1   decimal point segment, active-low
//   frame     out  1   pulse on the first cycle of each digit-0 slot
// -----------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int DIV  = 50000,
  parameter int DEAD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  value,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_data_q, shadow_data_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_q, pend_d;

  // Registered outputs
  logic [3:0]    value_q, value_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          boundary;
  logic [3:0]    lz_blank;
  logic          in_dead;
  logic          lit;

  assign boundary = (cnt_q == LAST);

  // ---------------------------------------------------------------------------
  // Counter, index and pending/shadow transfer
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d         = cnt_q + CW'(1);
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_d        = pend_q;

    if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp_in;
      pend_d      = 1'b1;
    end

    if (boundary) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      // A load in the last cycle of a slot bypasses the pending register so
      // the very next slot already shows it.
      if (load) begin
        shadow_data_d = data;
        shadow_dp_d   = dp_in;
        pend_d        = 1'b0;
      end else if (pend_q) begin
        shadow_data_d = pend_data_q;
        shadow_dp_d   = pend_dp_q;
        pend_d        = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection on the next shadow value: digit i is a leading
  // zero when every digit from 3 down to i is zero. Digit 0 always shows.
  // ---------------------------------------------------------------------------
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign lz_blank[gi] = (shadow_data_d[15:4*gi] == '0);
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are computed from the next state and registered,
  // so what appears in the cycle with cnt=k is decoded from cnt=k itself and
  // there is no combinational path from any input to any output.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_dead = (int'(cnt_d) < DEAD);
    lit     = !in_dead && !(blank_lz && lz_blank[idx_d]);

    value_d = shadow_data_d[4*idx_d +: 4];
    an_d    = 4'b1111;
    dp_d    = 1'b1;
    if (lit) begin
      an_d = ~(4'b0001 << idx_d);
      dp_d = ~shadow_dp_d[idx_d];
    end
    frame_d = (idx_d == 2'd0) && (cnt_d == '0);
  end

  // ---------------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_q        <= 1'b0;
      value_q       <= 4'h0;
      an_q          <= 4'b1111;
      dp_q          <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_q        <= pend_d;
      value_q       <= value_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      frame_q       <= frame_d;
    end
  end

  assign value = value_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Directed and randomized stimulus for seg_scan_mux (DIV=8, DEAD=2). A
// reference model tracks the number of clock edges since reset release and
// the pending/shown words; expected outputs are derived from slot position
// arithmetic on that count.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  value;
  logic [3:0]  an;
  logic        dp;
  logic        frame;

  seg_scan_mux #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .value    (value),
    .an       (an),
    .dp       (dp),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit          m_in_rst;
  int          m_n;        // clock edges since reset release
  logic [15:0] m_shown;
  logic [3:0]  m_shown_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  bit          m_pflag;
  bit          m_blank;

  function automatic int m_cnt();
    return m_n % DIV;
  endfunction

  function automatic int m_idx();
    return (m_n / DIV) % 4;
  endfunction

  function automatic bit m_lit();
    int i;
    bit leading_zero;
    i = m_idx();
    leading_zero = (i > 0) && ((m_shown >> (4 * i)) == 16'h0);
    return !m_in_rst && (m_cnt() >= DEAD) && !(m_blank && leading_zero);
  endfunction

  function automatic logic [3:0] exp_value();
    if (m_in_rst) return 4'h0;
    return 4'((m_shown >> (4 * m_idx())) & 16'hF);
  endfunction

  function automatic logic [3:0] exp_an();
    if (!m_lit()) return 4'b1111;
    return ~(4'b0001 << m_idx());
  endfunction

  function automatic logic exp_dp();
    if (!m_lit()) return 1'b1;
    return ~m_shown_dp[m_idx()];
  endfunction

  function automatic logic exp_frame();
    return !m_in_rst && ((m_n % (4 * DIV)) == 0);
  endfunction

  task automatic model_reset();
    m_in_rst   = 1'b1;
    m_n        = 0;
    m_shown    = '0;
    m_shown_dp = '0;
    m_pend     = '0;
    m_pend_dp  = '0;
    m_pflag    = 1'b0;
    m_blank    = 1'b0;
  endtask

  // One rising edge with reset released.
  task automatic model_edge(bit ld, logic [15:0] d, logic [3:0] p);
    bit at_boundary;
    at_boundary = (m_cnt() == DIV - 1);
    m_in_rst = 1'b0;
    m_blank  = blank_lz;
    if (ld) begin
      m_pend    = d;
      m_pend_dp = p;
      m_pflag   = 1'b1;
    end
    if (at_boundary && m_pflag) begin
      m_shown    = m_pend;
      m_shown_dp = m_pend_dp;
      m_pflag    = 1'b0;
    end
    m_n++;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at t=%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("value", 16'(value), 16'(exp_value()));
    chk("an",    16'(an),    16'(exp_an()));
    chk("dp",    16'(dp),    16'(exp_dp()));
    chk("frame", 16'(frame), 16'(exp_frame()));
  endtask

  // Drive inputs for one cycle, clock, update the model and check outputs.
  task automatic tick(bit ld, logic [15:0] d, logic [3:0] p);
    load  = ld;
    data  = d;
    dp_in = p;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(ld, d, p);
    #1;
    load = 1'b0;
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0);
  endtask

  // Advance until the current state is (idx ti, cnt tc).
  task automatic run_to(int ti, int tc);
    int guard;
    guard = 0;
    while (!(m_cnt() == tc && m_idx() == ti) && guard <= 4 * DIV + 2) begin
      tick(1'b0, 16'h0, 4'h0);
      guard++;
    end
    chk("run_to_reached", 16'(m_cnt() == tc && m_idx() == ti), 16'h1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] rd;
    rst      = 1'b1;
    load     = 1'b0;
    data     = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    model_reset();

    // Reset held for three cycles.
    idle(3);
    chk("reset_an",    16'(an),    16'hF);
    chk("reset_value", 16'(value), 16'h0);
    chk("reset_dp",    16'(dp),    16'h1);
    chk("reset_frame", 16'(frame), 16'h0);

    // Release: cnt=1 after the first edge, then digit 0 lit from cnt=2.
    rst = 1'b0;
    idle(1);
    chk("first_dead_an", 16'(an), 16'hF);
    idle(1);
    chk("first_lit_an", 16'(an), 16'hE);
    idle(29);                              // now m_n = 31
    chk("no_frame_yet", 16'(frame), 16'h0);
    idle(1);                               // m_n = 32
    chk("first_frame", 16'(frame), 16'h1);

    // Basic scan: load at the last cycle of digit 3 so the next frame shows it.
    run_to(3, DIV - 1);
    tick(1'b1, 16'h1A2F, 4'b0100);
    chk("scan_d0_value", 16'(value), 16'hF);
    idle(2);
    chk("scan_d0_an", 16'(an), 16'hE);
    run_to(2, 4);
    chk("scan_d2_value", 16'(value), 16'hA);
    chk("scan_d2_dp",    16'(dp),    16'h0);
    run_to(3, 4);
    chk("scan_d3_an", 16'(an), 16'h7);
    chk("scan_d3_dp", 16'(dp), 16'h1);

    // Mid-slot load stays hidden until the boundary.
    run_to(1, 3);
    tick(1'b1, 16'h1111, 4'h0);
    chk("midslot_hold", 16'(value), 16'h2);
    run_to(2, 0);
    chk("midslot_after", 16'(value), 16'h1);

    // Two loads in one slot: the second wins.
    run_to(2, 2);
    tick(1'b1, 16'h2222, 4'h0);
    tick(1'b1, 16'h3333, 4'h0);
    run_to(3, 2);
    chk("double_load", 16'(value), 16'h3);

    // Boundary load: visible in the very next slot.
    run_to(0, DIV - 1);
    tick(1'b1, 16'h00C0, 4'h0);
    chk("boundary_load", 16'(value), 16'hC);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    run_to(3, DIV - 1);
    tick(1'b1, 16'h0050, 4'h0);
    run_to(1, 4);
    chk("lz_d1_value", 16'(value), 16'h5);
    chk("lz_d1_an",    16'(an),    16'hD);
    run_to(2, 4);
    chk("lz_d2_an",    16'(an),    16'hF);
    run_to(3, 5);
    chk("lz_d3_an",    16'(an),    16'hF);
    tick(1'b1, 16'h0000, 4'b1000);
    run_to(3, 4);
    chk("lz_zero_dp",  16'(dp),    16'h1);
    run_to(0, 4);
    chk("lz_zero_d0",  16'(an),    16'hE);
    idle(4 * DIV);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd = rd >> (4 * $urandom_range(1, 4));
      tick($urandom_range(0, 5) == 0, rd, 4'($urandom));
    end

    // Reset mid-operation with a load pending.
    blank_lz = 1'b0;
    run_to(2, 3);
    tick(1'b1, 16'hA5A5, 4'hF);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("midrst_an", 16'(an), 16'hF);
    idle(2);
    rst = 1'b0;
    idle(4 * DIV + 8);
    run_to(0, 4);
    chk("post_rst_value", 16'(value), 16'h0);
    chk("post_rst_an",    16'(an),    16'hE);
    run_to(2, 4);
    chk("post_rst_d2",    16'(value), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
